// File: rtl/noc_inject_arbiter.sv
// Round-robin packet arbiter for the NoC injection port with wormhole lock:
// a winning head flit holds the port for its requester until the tail is accepted.
module noc_inject_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned FLIT_WIDTH = 129,
    parameter int unsigned MAX_FLITS  = 258
) (
    input  logic                          noc_clk,
    input  logic                          noc_rst,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ-1:0]            req_head,
    input  logic [NUM_REQ-1:0]            req_tail,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic [FLIT_WIDTH-1:0]         nocdata,
    output logic                          m_is_head,
    output logic                          m_is_tail,
    output logic                          m_vld,
    input  logic                          buffer_busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          pkt_err
);

    localparam int unsigned OW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_FLITS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_FLITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_FLITS - 1);
    localparam logic [OW-1:0] IDX_LAST = OW'(NUM_REQ - 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                state_q, state_d;
    logic [FLIT_WIDTH-1:0] data_q, data_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic                  vld_q, vld_d;
    logic [OW-1:0]         owner_q, owner_d;
    logic [OW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic [FLIT_WIDTH-1:0] flit_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    eligible;
    logic [OW-1:0]         winner;
    logic [OW-1:0]         sel;
    logic                  is_lock;
    logic                  slot_free;
    logic                  grant;
    logic                  accept;
    logic                  force_tail;
    logic                  release_pkt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign flit_arr[g] = req_flit[g*FLIT_WIDTH +: FLIT_WIDTH];
    end

    // First set bit of elig at or after start, wrapping to index 0.
    function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                              input logic [OW-1:0] start);
        logic [OW-1:0] pick;
        logic [OW-1:0] idx;
        logic          found;
        int unsigned   pos;
        pick  = start;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = 32'(start) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            idx = OW'(pos);
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] cur);
        return (cur == IDX_LAST) ? '0 : cur + 1'b1;
    endfunction

    always_comb begin : arb_comb
        slot_free   = !vld_q || !buffer_busy;
        eligible    = req_vld & req_head;
        winner      = rr_pick(eligible, ptr_q);
        is_lock     = (state_q == LOCK);
        sel         = is_lock ? owner_q : winner;
        grant       = slot_free && (is_lock || (|eligible));
        accept      = grant && req_vld[sel];
        force_tail  = is_lock && (cnt_q == CNT_MAX);
        release_pkt = accept && (req_tail[sel] || force_tail);
    end

    always_ff @(posedge noc_clk) begin : state_reg
        if (noc_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin : fsm_next
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && !release_pkt) state_d = LOCK;
            LOCK:    if (release_pkt)            state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : dp_next
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        vld_d   = vld_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (accept) begin
            data_d = flit_arr[sel];
            head_d = req_head[sel];
            tail_d = req_tail[sel] | force_tail;
            vld_d  = 1'b1;
        end else if (slot_free) begin
            vld_d = 1'b0;
        end

        if (accept && !is_lock) owner_d = winner;
        if (release_pkt)        ptr_d   = next_idx(sel);

        // Counter stays 0 while idle; saturates at MAX_FLITS until the forced release.
        if (release_pkt)                          cnt_d = '0;
        else if (accept && !is_lock)              cnt_d = CW'(1);
        else if (accept && (cnt_q != CNT_MAX))    cnt_d = cnt_q + 1'b1;

        if (!is_lock && (|(req_vld & ~req_head))) err_d = 1'b1;
        if (accept && is_lock && !release_pkt && (cnt_q == CNT_LAST)) err_d = 1'b1;
    end

    always_ff @(posedge noc_clk) begin : dp_reg
        if (noc_rst) begin
            data_q  <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            vld_q   <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            vld_q   <= vld_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin : out_comb
        req_rdy = '0;
        if (grant) req_rdy[sel] = 1'b1;
    end

    assign nocdata   = data_q;
    assign m_is_head = head_q;
    assign m_is_tail = tail_q;
    assign m_vld     = vld_q;
    assign owner     = owner_q;
    assign pkt_err   = err_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Table-driven bench for noc_inject_arbiter with a scoreboard of expected output flits;
// small MAX_FLITS so the length watchdog is reachable.
module tb_noc_inject_arbiter;

    localparam int NR = 3;
    localparam int FW = 129;
    localparam int MF = 4;

    logic             clk = 1'b0;
    logic             noc_rst;
    logic [NR*FW-1:0] req_flit;
    logic [NR-1:0]    req_vld, req_head, req_tail, req_rdy;
    logic [FW-1:0]    nocdata;
    logic             m_is_head, m_is_tail, m_vld, buffer_busy, pkt_err;
    logic [1:0]       owner;

    int checks   = 0;
    int failures = 0;

    noc_inject_arbiter #(.NUM_REQ(NR), .FLIT_WIDTH(FW), .MAX_FLITS(MF)) dut (
        .noc_clk(clk), .noc_rst(noc_rst), .req_flit(req_flit), .req_vld(req_vld),
        .req_head(req_head), .req_tail(req_tail), .req_rdy(req_rdy), .nocdata(nocdata),
        .m_is_head(m_is_head), .m_is_tail(m_is_tail), .m_vld(m_vld),
        .buffer_busy(buffer_busy), .owner(owner), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] vld, head, tail;
        logic       busy;
        logic [7:0] tag;
        logic [2:0] rdy;
        logic       mvld;
        logic       ftail;
        logic [1:0] own;
        logic       err;
    } vec_t;

    typedef struct {
        logic [FW-1:0] data;
        logic          head;
        logic          tail;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t last_e, e;
    vec_t v;

    function automatic logic [FW-1:0] make_flit(input int i, input logic [7:0] tag);
        return {1'b1, 8'(i), tag, 112'h0123456789ABCDEFFEDCBA987654};
    endfunction

    task automatic add(input logic r, input logic [2:0] vld, input logic [2:0] head,
                       input logic [2:0] tail, input logic busy, input logic [7:0] tag,
                       input logic [2:0] rdy, input logic mvld, input logic ftail,
                       input logic [1:0] own, input logic err);
        vec_t t;
        t.rst = r; t.vld = vld; t.head = head; t.tail = tail; t.busy = busy; t.tag = tag;
        t.rdy = rdy; t.mvld = mvld; t.ftail = ftail; t.own = own; t.err = err;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic [2:0] vld, input logic [2:0] head,
                         input logic [2:0] tail, input logic busy, input logic [7:0] tag);
        noc_rst     = r;
        req_vld     = vld;
        req_head    = head;
        req_tail    = tail;
        buffer_busy = busy;
        for (int i = 0; i < NR; i++) req_flit[i*FW +: FW] = make_flit(i, tag);
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // single req0 packet head+2 data+tail, then a req2 single-flit packet (ptr -> 0)
        add(0, 3'b001, 3'b001, 3'b000, 0, 8'd1, 3'b001, 1, 0, 2'd0, 0);
        add(0, 3'b001, 3'b000, 3'b000, 0, 8'd2, 3'b001, 1, 0, 2'd0, 0);
        add(0, 3'b001, 3'b000, 3'b000, 0, 8'd3, 3'b001, 1, 0, 2'd0, 0);
        add(0, 3'b001, 3'b000, 3'b001, 0, 8'd4, 3'b001, 1, 0, 2'd0, 0);
        add(0, 3'b000, 3'b000, 3'b000, 0, 8'd5, 3'b000, 0, 0, 2'd0, 0);
        add(0, 3'b100, 3'b100, 3'b100, 0, 8'd6, 3'b100, 1, 0, 2'd2, 0);
        add(0, 3'b000, 3'b000, 3'b000, 0, 8'd7, 3'b000, 0, 0, 2'd2, 0);
        // three simultaneous 2-flit packets, two rounds: order 0,1,2 each time
        for (int r = 0; r < 2; r++) begin
            add(0, 3'b111, 3'b111, 3'b000, 0, 8'(10*r+10), 3'b001, 1, 0, 2'd0, 0);
            add(0, 3'b111, 3'b110, 3'b001, 0, 8'(10*r+11), 3'b001, 1, 0, 2'd0, 0);
            add(0, 3'b110, 3'b110, 3'b000, 0, 8'(10*r+12), 3'b010, 1, 0, 2'd1, 0);
            add(0, 3'b110, 3'b100, 3'b010, 0, 8'(10*r+13), 3'b010, 1, 0, 2'd1, 0);
            add(0, 3'b100, 3'b100, 3'b000, 0, 8'(10*r+14), 3'b100, 1, 0, 2'd2, 0);
            add(0, 3'b100, 3'b000, 3'b100, 0, 8'(10*r+15), 3'b100, 1, 0, 2'd2, 0);
        end
        add(0, 3'b000, 3'b000, 3'b000, 0, 8'd40, 3'b000, 0, 0, 2'd2, 0);
        // req1 locked, 5 busy cycles mid-packet
        add(0, 3'b010, 3'b010, 3'b000, 0, 8'd41, 3'b010, 1, 0, 2'd1, 0);
        add(0, 3'b010, 3'b000, 3'b000, 0, 8'd42, 3'b010, 1, 0, 2'd1, 0);
        for (int k = 0; k < 5; k++)
            add(0, 3'b010, 3'b000, 3'b000, 1, 8'd43, 3'b000, 1, 0, 2'd1, 0);
        add(0, 3'b010, 3'b000, 3'b000, 0, 8'd43, 3'b010, 1, 0, 2'd1, 0);
        add(0, 3'b010, 3'b000, 3'b010, 0, 8'd44, 3'b010, 1, 0, 2'd1, 0);
        add(0, 3'b000, 3'b000, 3'b000, 0, 8'd45, 3'b000, 0, 0, 2'd1, 0);
        // busy with empty output still accepts; busy with full output freezes it
        add(0, 3'b100, 3'b100, 3'b100, 1, 8'd46, 3'b100, 1, 0, 2'd2, 0);
        add(0, 3'b000, 3'b000, 3'b000, 1, 8'd47, 3'b000, 1, 0, 2'd2, 0);
        add(0, 3'b000, 3'b000, 3'b000, 0, 8'd48, 3'b000, 0, 0, 2'd2, 0);
        // length overrun: req0 never sends tail, req1 waits with a head
        add(0, 3'b011, 3'b011, 3'b000, 0, 8'd50, 3'b001, 1, 0, 2'd0, 0);
        add(0, 3'b011, 3'b010, 3'b000, 0, 8'd51, 3'b001, 1, 0, 2'd0, 0);
        add(0, 3'b011, 3'b010, 3'b000, 0, 8'd52, 3'b001, 1, 0, 2'd0, 0);
        add(0, 3'b011, 3'b010, 3'b000, 0, 8'd53, 3'b001, 1, 0, 2'd0, 1);
        add(0, 3'b011, 3'b010, 3'b000, 0, 8'd54, 3'b001, 1, 1, 2'd0, 1);
        add(0, 3'b011, 3'b010, 3'b000, 0, 8'd55, 3'b010, 1, 0, 2'd1, 1);
        add(0, 3'b010, 3'b000, 3'b010, 0, 8'd56, 3'b010, 1, 0, 2'd1, 1);
        add(0, 3'b000, 3'b000, 3'b000, 0, 8'd57, 3'b000, 0, 0, 2'd1, 1);
        // reset clears the sticky error, then a headless flit sets it again
        add(1, 3'b000, 3'b000, 3'b000, 0, 8'd58, 3'b000, 0, 0, 2'd0, 0);
        add(0, 3'b100, 3'b000, 3'b000, 0, 8'd59, 3'b000, 0, 0, 2'd0, 1);
        add(0, 3'b000, 3'b000, 3'b000, 0, 8'd60, 3'b000, 0, 0, 2'd0, 1);

        drive(1, 3'b000, 3'b000, 3'b000, 0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset req_rdy", req_rdy, 3'b000);
        check("reset m_vld", m_vld, 1'b0);
        check("reset nocdata", nocdata, '0);
        check("reset m_is_head", m_is_head, 1'b0);
        check("reset m_is_tail", m_is_tail, 1'b0);
        check("reset owner", owner, 2'd0);
        check("reset pkt_err", pkt_err, 1'b0);

        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            @(negedge clk);
            drive(v.rst, v.vld, v.head, v.tail, v.busy, v.tag);
            #1;
            check($sformatf("v%0d req_rdy", n), req_rdy, v.rdy);
            for (int i = 0; i < NR; i++) begin
                if (v.rdy[i] && v.vld[i]) begin
                    e.data = make_flit(i, v.tag);
                    e.head = v.head[i];
                    e.tail = v.tail[i] | v.ftail;
                    sb.push_back(e);
                end
            end
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("v%0d m_vld", n), m_vld, 1'b1);
                check($sformatf("v%0d nocdata", n), nocdata, e.data);
                check($sformatf("v%0d m_is_head", n), m_is_head, e.head);
                check($sformatf("v%0d m_is_tail", n), m_is_tail, e.tail);
                last_e = e;
            end else begin
                check($sformatf("v%0d m_vld", n), m_vld, v.mvld);
                if (v.mvld) check($sformatf("v%0d held nocdata", n), nocdata, last_e.data);
            end
            check($sformatf("v%0d owner", n), owner, v.own);
            check($sformatf("v%0d pkt_err", n), pkt_err, v.err);
        end

        // reset in the middle of a locked req1 packet (pkt_err is 1 going in)
        @(negedge clk);
        drive(0, 3'b010, 3'b010, 3'b000, 0, 8'd70);
        #1;
        check("midrst head rdy", req_rdy, 3'b010);
        @(negedge clk);
        drive(0, 3'b010, 3'b000, 3'b000, 0, 8'd71);
        #1;
        check("midrst lock rdy", req_rdy, 3'b010);
        @(negedge clk);
        drive(1, 3'b010, 3'b000, 3'b000, 0, 8'd72);
        @(posedge clk);
        #1;
        check("midrst m_vld", m_vld, 1'b0);
        check("midrst owner", owner, 2'd0);
        check("midrst pkt_err", pkt_err, 1'b0);
        check("midrst req_rdy", req_rdy, 3'b000);
        @(negedge clk);
        drive(0, 3'b001, 3'b001, 3'b001, 0, 8'd73);
        #1;
        check("postrst rdy", req_rdy, 3'b001);
        @(posedge clk);
        #1;
        check("postrst m_vld", m_vld, 1'b1);
        check("postrst nocdata", nocdata, make_flit(0, 8'd73));
        check("postrst m_is_head", m_is_head, 1'b1);
        check("postrst m_is_tail", m_is_tail, 1'b1);
        check("postrst owner", owner, 2'd0);
        @(negedge clk);
        drive(0, 3'b000, 3'b000, 3'b000, 0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
